// File: rtl/exe_stage_ctrl_pkg.sv
// Shared types and constants for the EXE stage occupancy/handshake controller.
package exe_stage_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_EXEC  = 2'd1,
    ST_DONE  = 2'd2
  } exe_state_e;

  localparam int EXE_MC_LAT_DEF = 4;
  localparam int EXE_PERF_W     = 32;

endpackage

// File: rtl/exe_perf_cnt.sv
// Free-running enable-increment event counter, wraps modulo 2^EXE_PERF_W.
module exe_perf_cnt
  import exe_stage_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  i_en,
  output logic [EXE_PERF_W-1:0] o_cnt
);

  logic [EXE_PERF_W-1:0] r_cnt;

  // Count one per enabled cycle; synchronous clear.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + EXE_PERF_W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/exe_stage_ctrl.sv
// EXE stage slot controller: ID->EXE accept, multi-cycle sequencing, EXE->MEM
// handoff and taken-branch redirect. Optional perf counters under EXE_PERF_CNT_EN.
module exe_stage_ctrl
  import exe_stage_ctrl_pkg::*;
#(
  parameter int MC_LAT = EXE_MC_LAT_DEF,
  parameter int CNT_W  = 3
) (
  input  logic clk,
  input  logic resetn,
  input  logic Dvalid,
  input  logic MultiCycleD,
  output logic Eready,
  output logic Evalid,
  input  logic Mready,
  input  logic BranchTakenE,
  output logic Redirect,
  output logic Flush,
  output logic Busy
`ifdef EXE_PERF_CNT_EN
  ,
  output logic [EXE_PERF_W-1:0] PerfBusy,
  output logic [EXE_PERF_W-1:0] PerfBp,
  output logic [EXE_PERF_W-1:0] PerfRet
`endif
);

  exe_state_e       r_state;
  exe_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_accept;
  logic             w_handoff;
  logic             w_flush;

  assign Evalid    = (r_state == ST_DONE);
  assign Busy      = (r_state == ST_EXEC);
  assign w_handoff = Evalid && Mready;
  assign w_flush   = w_handoff && BranchTakenE;
  assign Redirect  = w_flush;
  assign Flush     = w_flush;
  // A flush cycle never accepts, so a retiring branch always leaves the slot EMPTY.
  assign Eready    = !w_flush && ((r_state == ST_EMPTY) || ((r_state == ST_DONE) && Mready));
  assign w_accept  = Dvalid && Eready;

  // Next-state and latency counter update.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          if (MultiCycleD) begin
            w_state_nxt = ST_EXEC;
            w_cnt_nxt   = CNT_W'(MC_LAT - 1);
          end else begin
            w_state_nxt = ST_DONE;
          end
        end else begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_EXEC: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (w_handoff) begin
          if (w_accept && MultiCycleD) begin
            w_state_nxt = ST_EXEC;
            w_cnt_nxt   = CNT_W'(MC_LAT - 1);
          end else if (w_accept) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_EMPTY;
          end
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      default: begin
        w_state_nxt = ST_EMPTY;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State and counter registers; reset discards any in-flight slot.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= ST_EMPTY;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

`ifdef EXE_PERF_CNT_EN
  exe_perf_cnt u_perf_busy (
    .clk    (clk),
    .resetn (resetn),
    .i_en   (Busy),
    .o_cnt  (PerfBusy)
  );

  exe_perf_cnt u_perf_bp (
    .clk    (clk),
    .resetn (resetn),
    .i_en   (Evalid && !Mready),
    .o_cnt  (PerfBp)
  );

  exe_perf_cnt u_perf_ret (
    .clk    (clk),
    .resetn (resetn),
    .i_en   (w_handoff),
    .o_cnt  (PerfRet)
  );
`endif

endmodule

// File: tb/tb_exe_stage_ctrl.sv
// Directed self-checking bench for exe_stage_ctrl (MC_LAT = 4, CNT_W = 3).
module tb_exe_stage_ctrl;
  logic clk = 1'b0;
  logic resetn, Dvalid, MultiCycleD, Mready, BranchTakenE;
  logic Eready, Evalid, Redirect, Flush, Busy;
`ifdef EXE_PERF_CNT_EN
  logic [31:0] PerfBusy, PerfBp, PerfRet;
`endif

  int total = 0;
  int bad   = 0;

  exe_stage_ctrl #(.MC_LAT(4), .CNT_W(3)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .Dvalid       (Dvalid),
    .MultiCycleD  (MultiCycleD),
    .Eready       (Eready),
    .Evalid       (Evalid),
    .Mready       (Mready),
    .BranchTakenE (BranchTakenE),
    .Redirect     (Redirect),
    .Flush        (Flush),
    .Busy         (Busy)
`ifdef EXE_PERF_CNT_EN
    ,
    .PerfBusy     (PerfBusy),
    .PerfBp       (PerfBp),
    .PerfRet      (PerfRet)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge, then let inputs/outputs settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn = 1'b0; Dvalid = 1'b0; MultiCycleD = 1'b0; Mready = 1'b0; BranchTakenE = 1'b0;
    tick(); tick();
    resetn = 1'b1;
    #1;
    chk("rst_evalid", {31'd0, Evalid}, 32'd0);
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    chk("rst_eready", {31'd0, Eready}, 32'd1);
    chk("rst_redirect", {31'd0, Redirect}, 32'd0);
    chk("rst_flush", {31'd0, Flush}, 32'd0);
`ifdef EXE_PERF_CNT_EN
    chk("rst_perfret", PerfRet, 32'd0);
`endif

    // Back-to-back single-cycle ops with Mready high.
    Dvalid = 1'b1; MultiCycleD = 1'b0; Mready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("sc_eready", {31'd0, Eready}, 32'd1);
      tick();
      chk("sc_evalid", {31'd0, Evalid}, 32'd1);
      chk("sc_busy", {31'd0, Busy}, 32'd0);
    end
    Dvalid = 1'b0;
    tick();
    chk("sc_drain", {31'd0, Evalid}, 32'd0);
`ifdef EXE_PERF_CNT_EN
    chk("sc_perfret", PerfRet, 32'd5);
`endif

    // Multi-cycle op; Dvalid held high during EXEC must be ignored.
    Dvalid = 1'b1; MultiCycleD = 1'b1;
    #1;
    chk("mc_eready_empty", {31'd0, Eready}, 32'd1);
    tick();
    MultiCycleD = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      #1;
      chk("mc_busy", {31'd0, Busy}, 32'd1);
      chk("mc_eready", {31'd0, Eready}, 32'd0);
      chk("mc_evalid", {31'd0, Evalid}, 32'd0);
      tick();
    end
    chk("mc_done_busy", {31'd0, Busy}, 32'd0);
    chk("mc_done_evalid", {31'd0, Evalid}, 32'd1);
    chk("mc_done_eready", {31'd0, Eready}, 32'd1);
`ifdef EXE_PERF_CNT_EN
    chk("mc_perfbusy", PerfBusy, 32'd4);
`endif

    // Backpressure: three cycles with Mready low.
    Mready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      #1;
      chk("bp_evalid", {31'd0, Evalid}, 32'd1);
      chk("bp_eready", {31'd0, Eready}, 32'd0);
      tick();
    end
    Mready = 1'b1; Dvalid = 1'b0;
    #1;
    chk("bp_release_eready", {31'd0, Eready}, 32'd1);
`ifdef EXE_PERF_CNT_EN
    chk("bp_perfbp", PerfBp, 32'd3);
`endif
    tick();
    chk("bp_handoff", {31'd0, Evalid}, 32'd0);

    // Taken branch retires: one-cycle redirect, no accept, slot empties.
    Dvalid = 1'b1; MultiCycleD = 1'b0;
    tick();
    BranchTakenE = 1'b1;
    #1;
    chk("br_redirect", {31'd0, Redirect}, 32'd1);
    chk("br_flush", {31'd0, Flush}, 32'd1);
    chk("br_eready", {31'd0, Eready}, 32'd0);
    tick();
    chk("br_after_evalid", {31'd0, Evalid}, 32'd0);
    chk("br_after_redirect", {31'd0, Redirect}, 32'd0);
    chk("br_after_eready", {31'd0, Eready}, 32'd1);
    BranchTakenE = 1'b0;
    tick();
    chk("br_next_accept", {31'd0, Evalid}, 32'd1);
    Dvalid = 1'b0;
    tick();
    chk("br_drain", {31'd0, Evalid}, 32'd0);
`ifdef EXE_PERF_CNT_EN
    chk("br_perfret", PerfRet, 32'd8);
`endif

    // Reset in the middle of a multi-cycle op.
    Dvalid = 1'b1; MultiCycleD = 1'b1;
    tick();
    Dvalid = 1'b0; MultiCycleD = 1'b0;
    tick();
    resetn = 1'b0;
    #1;
    chk("rmid_busy_before", {31'd0, Busy}, 32'd1);
    tick();
    chk("rmid_busy", {31'd0, Busy}, 32'd0);
    chk("rmid_evalid", {31'd0, Evalid}, 32'd0);
    chk("rmid_eready", {31'd0, Eready}, 32'd1);
`ifdef EXE_PERF_CNT_EN
    chk("rmid_perfbusy", PerfBusy, 32'd0);
    chk("rmid_perfbp", PerfBp, 32'd0);
    chk("rmid_perfret", PerfRet, 32'd0);
`endif
    resetn = 1'b1;
    for (int m = 0; m < 4; m++) begin
      tick();
      chk("rmid_no_evalid", {31'd0, Evalid}, 32'd0);
    end

`ifdef EXE_PERF_CNT_EN
    // Retire counter wraps.
    Dvalid = 1'b1; MultiCycleD = 1'b0; Mready = 1'b1;
    tick();
    Dvalid = 1'b0;
    force dut.u_perf_ret.r_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.u_perf_ret.r_cnt;
    tick();
    chk("wrap_perfret", PerfRet, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
